// File: rtl/bram_dot_engine_pkg.sv
// Shared types and sizing helpers for the BRAM-fed dot-product engine.
package dot_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int PIPE_LAT  = 3;
    localparam int DEF_LANES = 3;
    localparam int BANKS     = 2 * DEF_LANES;

    // Width of the registered per-address sum of LANES products.
    function automatic int lane_sum_w(input int lanes, input int data_w);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/dp_bram.sv
// Single-port read-first block RAM with a registered read port; only the
// output register is cleared by reset, never the array.
module dp_bram
    import dot_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/bram_dot_engine.sv
// Streams len addresses through 2*LANES operand banks, accumulates the sum of
// A*B lane products, and optionally writes the low result byte back to bank 0.
module bram_dot_engine
    import dot_engine_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 32,
    parameter bit WB_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [ADDR_W-1:0]            len,
    input  logic [ADDR_W-1:0]            res_addr,
    input  logic                         ld_we,
    input  logic [$clog2(2*LANES)-1:0]   ld_bank,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         busy,
    output logic                         done,
    output logic [ACC_W-1:0]             result,
    output logic                         overflow
);

    localparam int NBANK = 2 * LANES;
    localparam int SEL_W = $clog2(NBANK);
    localparam int LS_W  = lane_sum_w(LANES, DATA_W);
    localparam int SUM_W = ((ACC_W > LS_W) ? ACC_W : LS_W) + 1;

    // Wrapping add; the top bit reports whether anything carried past ACC_W.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [LS_W-1:0]  s);
        logic [SUM_W-1:0] full;
        full = SUM_W'(acc) + SUM_W'(s);
        return {|full[SUM_W-1:ACC_W], full[ACC_W-1:0]};
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_res_addr;
    logic [1:0]        r_drain;
    logic              w_accept;

    logic              w_bank_we    [NBANK];
    logic [ADDR_W-1:0] w_bank_addr  [NBANK];
    logic [DATA_W-1:0] w_bank_wdata [NBANK];
    logic [DATA_W-1:0] w_bank_rdata [NBANK];

    logic              r_vld_p0;
    logic              r_vld_p1;
    logic [LS_W-1:0]   w_lane_sum;
    logic [LS_W-1:0]   r_sum_p1;
    logic [ACC_W-1:0]  r_acc_p2;
    logic              r_ovf_p2;
    logic [ACC_W:0]    w_acc_add;
    logic [ACC_W-1:0]  r_result;
    logic [SEL_W-1:0]  r_rd_sel;

    assign w_accept = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = (len == '0) ? ST_FIN : ST_RUN;
            ST_RUN:   if (r_cnt == ADDR_W'(1)) w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain == 2'(PIPE_LAT - 1)) w_next = ST_FIN;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_res_addr <= '0;
            r_drain    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_cnt      <= len;
                        r_res_addr <= res_addr;
                        r_drain    <= '0;
                    end
                end
                ST_RUN: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt - ADDR_W'(1);
                end
                ST_DRAIN: r_drain <= r_drain + 2'd1;
                default: ;
            endcase
        end
    end

    // Host owns the banks only in IDLE; FIN write-back takes over bank 0.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            w_bank_we[b]    = ld_we && (r_state == ST_IDLE) && (ld_bank == SEL_W'(b));
            w_bank_addr[b]  = busy ? r_addr : ld_addr;
            w_bank_wdata[b] = ld_data;
        end
        if (r_state == ST_FIN) begin
            w_bank_we[0]    = WB_EN;
            w_bank_addr[0]  = r_res_addr;
            w_bank_wdata[0] = r_result[DATA_W-1:0];
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        dp_bram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (w_bank_we[b]),
            .addr  (w_bank_addr[b]),
            .wdata (w_bank_wdata[b]),
            .rdata (w_bank_rdata[b])
        );
    end

    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum
                       + LS_W'(w_bank_rdata[l]) * LS_W'(w_bank_rdata[LANES + l]);
        end
    end

    assign w_acc_add = acc_add(r_acc_p2, r_sum_p1);

    // p0 = bank output registers, p1 = lane sum, p2 = accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_sum_p1 <= '0;
            r_acc_p2 <= '0;
            r_ovf_p2 <= 1'b0;
            r_result <= '0;
            r_rd_sel <= '0;
        end else begin
            r_vld_p0 <= (r_state == ST_RUN);
            r_vld_p1 <= r_vld_p0;
            r_rd_sel <= ld_bank;
            if (r_vld_p0) begin
                r_sum_p1 <= w_lane_sum;
            end
            if (w_accept) begin
                r_acc_p2 <= '0;
                r_ovf_p2 <= 1'b0;
            end else if (r_vld_p1) begin
                r_acc_p2 <= w_acc_add[ACC_W-1:0];
                r_ovf_p2 <= r_ovf_p2 | w_acc_add[ACC_W];
            end
            if (w_next == ST_FIN) begin
                r_result <= (r_state == ST_IDLE) ? '0 : r_acc_p2;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (r_rd_sel == SEL_W'(b)) rd_data = w_bank_rdata[b];
        end
    end

    assign result   = r_result;
    assign overflow = r_ovf_p2;

endmodule

// File: tb/tb_bram_dot_engine.sv
// Randomized scoreboard bench for bram_dot_engine (LANES=3, ACC_W=16, WB_EN=1).
module tb_bram_dot_engine;

    localparam int ACC_MOD = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  len = '0;
    logic [7:0]  res_addr = '0;
    logic        ld_we = 1'b0;
    logic [2:0]  ld_bank = '0;
    logic [7:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;

    bram_dot_engine #(
        .LANES  (3),
        .DATA_W (8),
        .ADDR_W (8),
        .ACC_W  (16),
        .WB_EN  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .res_addr  (res_addr),
        .ld_we     (ld_we),
        .ld_bank   (ld_bank),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned res;
        int unsigned ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned mem [6][256];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_result", 32'(result), e.res);
                chk("sb_overflow", 32'(overflow), e.ovf);
                chk("sb_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic host_write(input int b, input int a, input int d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_bank = 3'(b);
        ld_addr = 8'(a);
        ld_data = 8'(d);
        mem[b][a] = d % 256;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input int b, input int a, input int exp);
        @(negedge clk);
        ld_bank = 3'(b);
        ld_addr = 8'(a);
        @(negedge clk);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic run_job(input int base, input int n, input int res, input bit poke);
        int unsigned acc;
        int unsigned ovf;
        int unsigned s;
        longint      t;
        int          a;
        int          dur;
        int          berr;
        exp_t        e;
        acc = 0;
        ovf = 0;
        for (int k = 0; k < n; k++) begin
            a = (base + k) % 256;
            s = 0;
            for (int l = 0; l < 3; l++) s += mem[l][a] * mem[3 + l][a];
            t = longint'(acc) + longint'(s);
            if (t >= ACC_MOD) ovf = 1;
            acc = int'(t % ACC_MOD);
        end
        mem[0][res] = acc % 256;
        dur = (n == 0) ? 1 : n + 4;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'(base);
        len       = 8'(n);
        res_addr  = 8'(res);
        e.res = acc;
        e.ovf = ovf;
        e.cyc = cyc + dur;
        sb_q.push_back(e);
        berr = 0;
        for (int i = 1; i <= dur + 1; i++) begin
            @(negedge clk);
            start = 1'b0;
            ld_we = 1'b0;
            if (poke && i == 2) begin
                ld_we   = 1'b1;
                ld_bank = 3'd1;
                ld_addr = 8'd5;
                ld_data = 8'(~mem[1][5]);
            end
            if ((n != 0 || i > dur) && (busy !== (i <= dur))) berr++;
        end
        ld_we = 1'b0;
        chk("busy_profile", 32'(berr), 32'd0);
        chk("done_seen", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish by time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        for (int b = 0; b < 6; b++)
            for (int a = 0; a < 256; a++)
                host_write(b, a, int'($urandom_range(0, 255)));

        // Basic sum with a blocked host write during the job.
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 3; l++) begin
                host_write(l, k, k + 1);
                host_write(3 + l, k, 2);
            end
        run_job(0, 4, 'h10, 1'b1);
        chk("basic_result", 32'(result), 32'd60);
        chk("basic_overflow", 32'(overflow), 32'd0);
        rd_check("wb_basic", 0, 'h10, 60);
        rd_check("busy_write_blocked", 1, 5, int'(mem[1][5]));

        // Zero length.
        host_write(0, 'h30, 'h55);
        run_job(0, 0, 'h30, 1'b0);
        chk("zero_result", 32'(result), 32'd0);
        rd_check("wb_zero", 0, 'h30, 0);

        // Address wrap: ones at 254,255,0,1; zeros at 253 and 2.
        for (int b = 0; b < 6; b++) begin
            host_write(b, 253, 0);
            host_write(b, 254, 1);
            host_write(b, 255, 1);
            host_write(b, 0, 1);
            host_write(b, 1, 1);
            host_write(b, 2, 0);
        end
        run_job(254, 4, 'h10, 1'b0);
        chk("wrap_result", 32'(result), 32'd12);
        run_job(253, 6, 'h11, 1'b0);
        chk("wrap_edges_result", 32'(result), 32'd12);

        // Overflow then a clean follow-up job.
        for (int b = 0; b < 6; b++) begin
            host_write(b, 100, 255);
            host_write(b, 101, 255);
            host_write(b, 102, 1);
        end
        run_job(100, 2, 'h40, 1'b0);
        chk("ovf_result", 32'(result), 32'd62470);
        chk("ovf_flag", 32'(overflow), 32'd1);
        run_job(102, 1, 'h41, 1'b0);
        chk("ovf_clear_result", 32'(result), 32'd3);
        chk("ovf_clear_flag", 32'(overflow), 32'd0);

        // Reset in cycle 3 of a len=8 job; a second start in cycle 2 is ignored.
        host_write(0, 'h20, 'hAB);
        @(negedge clk);
        start = 1'b1; base_addr = 8'd40; len = 8'd8; res_addr = 8'h20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 8'd3; base_addr = 8'd60;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        repeat (16) @(negedge clk);
        rd_check("midrst_no_wb", 0, 'h20, 'hAB);
        run_job(40, 8, 'h21, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            int bse, n, ra;
            for (int w = 0; w < 3; w++)
                host_write(int'($urandom_range(0, 5)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)));
            bse = int'($urandom_range(0, 255));
            n   = (j % 7 == 3) ? 0 : int'($urandom_range(1, 40));
            ra  = int'($urandom_range(0, 255));
            run_job(bse, n, ra, 1'b0);
            rd_check("rand_wb", 0, ra, int'(mem[0][ra]));
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_dot_engine.md
# bram_dot_engine

Parametrised successor to the fixed three-pair BRAM-fed MAC test block. It holds `2*LANES` operand BRAM banks: A banks 0..LANES-1 and B banks LANES..2*LANES-1. On `start` it streams `len` consecutive addresses through all banks, multiplies the pairs per lane, and accumulates the sum into an `ACC_W` result. It can optionally write the result back to A bank 0. A host load/read port fills and inspects the banks while the engine is idle. The block sits between host-side memory init logic and downstream result consumers in the DSP/BRAM benchmark designs.

## Interface
- `LANES`, 3, number of A/B operand pairs per address
- `DATA_W`, 8, operand and bank word width (unsigned)
- `ADDR_W`, 8, bank address width; depth is 2^ADDR_W
- `ACC_W`, 32, accumulator/result width
- `WB_EN`, 1, 1 = write `result[DATA_W-1:0]` to bank 0 at `res_addr` on completion
- `clk` in 1: sole clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin job; sampled only in IDLE
- `base_addr` in ADDR_W: first operand address; sampled with `start`
- `len` in ADDR_W: element count, 0..2^ADDR_W-1; sampled with `start`
- `res_addr` in ADDR_W: write-back address; sampled with `start`
- `ld_we` in 1: host write strobe
- `ld_bank` in clog2(2*LANES): host bank select
- `ld_addr` in ADDR_W: host address (read and write)
- `ld_data` in DATA_W: host write data
- `rd_data` out DATA_W: host read data, 1-cycle latency
- `busy` out 1: job in progress
- `done` out 1: one-cycle completion pulse
- `result` out ACC_W: last job's accumulated sum, held until the next `start`
- `overflow` out 1: sticky accumulator-wrap flag for the current job

## Operation
- FSM states: IDLE → RUN → DRAIN → FIN → IDLE.
  - IDLE with `start`=1 and `len`>0: go to RUN, clear the accumulator and `overflow`, set `busy`.
  - IDLE with `start`=1 and `len`=0: go directly to FIN.
- RUN presents `base_addr+k` to every bank for k = 0..len-1. The address wraps modulo 2^ADDR_W.
- Pipeline stages:
  - BRAM read register.
  - Registered lane sum Σ A_l·B_l, width `2*DATA_W+clog2(LANES)`.
  - Accumulator add, wrapping modulo 2^ACC_W. Any carry out sets `overflow`.
- DRAIN covers the 3 cycles after the last address and flushes the pipeline.
- FIN (1 cycle): pulse `done`, latch `result`, and perform the bank-0 write-back if `WB_EN`. Then return to IDLE and drop `busy`.
- `start` is ignored while `busy`. Host `ld_we` is ignored while `busy` or in FIN. `rd_data` is valid only for reads issued in IDLE.
- Banks are read-first: a same-address read returns the old data.
- `rst`:
  - FSM goes to IDLE; `busy`, `done`, `overflow`, `result`, `rd_data` and the pipeline all go to 0.
  - Bank contents are not reset.
  - Reset mid-job aborts the job with no write-back.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- For `len`=N>0:
  - Addresses are presented in cycles 1..N.
  - `done`=1 and write-back occur in cycle N+4.
  - `result` and `overflow` are valid from cycle N+4.
  - `busy`=1 in cycles 1..N+4.
- For `len`=0: `done` in cycle 1, `result`=0, write-back of 0 if `WB_EN`.
- A new `start` is accepted from cycle N+5.
- Host read: `ld_addr`/`ld_bank` in cycle t gives `rd_data` in cycle t+1.

## Structure
- Package `dot_engine_pkg`:
  - FSM state enum.
  - Constants `PIPE_LAT=3` and `BANKS=2*LANES`.
  - Function `lane_sum_w(LANES, DATA_W)`.
- Sub-module `dp_bram`: single-port, `DATA_W`×2^ADDR_W, registered read-first output, no reset on the array. Instantiated `2*LANES` times in a generate loop.
- Bank port mux: engine address when `busy`, host address otherwise; the FIN write-back overrides bank 0.

## Test plan
- **Basic sum:** LANES=3, A_l[k]=k+1, B_l[k]=2 for k=0..3; start with base=0, len=4 → `done` in cycle 8, `result`=60, `overflow`=0, `busy` high in cycles 1..8.
- **Zero length:** start with len=0 → `done` in cycle 1, `result`=0; bank 0 at `res_addr` reads 0 when `WB_EN`=1.
- **Address wrap:** base=254, len=4, A_l=B_l=1 at addresses 254, 255, 0, 1 and 0 elsewhere → `result`=12. Also check that addresses 2 and 253 contribute nothing.
- **Overflow:** ACC_W=16, all operands 255, len=2 → `result`=62470, `overflow`=1. A following job with len=1 on all-ones data gives `result`=3, `overflow`=0.
- **Write-back:** WB_EN=1, res_addr=0x10, then basic-sum job → host read of bank 0 at 0x10 returns 60 one cycle after the read address. A host `ld_we` issued while `busy` leaves its target unchanged.
- **Reset mid-run:** `rst` in cycle 3 of a len=8 job → next cycle `busy`=0 and `result`=0; bank 0 at `res_addr` is unchanged. A second `start` raised in cycle 2 has no effect. A fresh job after reset returns the correct sum.
